// File: rtl/uart_ram_arbiter_if.sv
// CPU data port, UART port and data-RAM port of the UART/RAM arbiter.
// The slave modport is the arbiter's view; master is the SoC/bench side.
interface uart_ram_arbiter_if #(parameter int ADDR_W = 16);
  logic [31:0]       cpu_addr;
  logic              cpu_wen;
  logic              cpu_ren;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic [31:0]       uart_addr;
  logic              uart_wen;
  logic [31:0]       uart_wdata;
  logic [31:0]       uart_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wen;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              irq;

  modport slave (
    input  cpu_addr, cpu_wen, cpu_ren, cpu_wdata, uart_addr, uart_wen, uart_wdata, ram_rdata,
    output cpu_rdata, cpu_stall, uart_rdata, ram_addr, ram_wen, ram_wdata, irq
  );

  modport master (
    output cpu_addr, cpu_wen, cpu_ren, cpu_wdata, uart_addr, uart_wen, uart_wdata, ram_rdata,
    input  cpu_rdata, cpu_stall, uart_rdata, ram_addr, ram_wen, ram_wdata, irq
  );
endinterface

// File: rtl/uart_ram_arbiter.sv
// Shares the data RAM between CPU and UART, hosts the UART mailbox registers
// and sequences UART TX/RX sessions with sticky status and an interrupt.
module uart_ram_arbiter #(
  parameter int          ADDR_W         = 16,
  parameter logic [31:0] MBOX_BASE      = 32'h0007_0000,
  parameter int          RX_IDLE_CYCLES = 1024,
  parameter int          CNT_W          = 16
) (
  input logic               clk,
  input logic               nrst,
  uart_ram_arbiter_if.slave bus
);
  localparam int TMR_W = $clog2(RX_IDLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_e;

  state_e            state_q, state_d;
  logic              cmd_q, cmd_d;
  logic [31:0]       err_q, err_d;
  logic              rx_done_q, rx_done_d, tx_done_q, tx_done_d, errf_q, errf_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic        cpu_mb, uart_mb, cpu_ram, uart_ram, cpu_grant;
  logic [1:0]  cpu_off, uart_off;
  logic        cpu_mb_wr, uart_err_wr, w1c;
  logic        set_rx, set_tx, clr_rx, go_tx;
  logic [31:0] cnt_ext, stat;

  assign cpu_mb      = bus.cpu_addr[31:2] == MBOX_BASE[31:2];
  assign uart_mb     = bus.uart_addr[31:2] == MBOX_BASE[31:2];
  assign cpu_off     = bus.cpu_addr[1:0];
  assign uart_off    = bus.uart_addr[1:0];
  assign cpu_ram     = (bus.cpu_wen | bus.cpu_ren) & ~cpu_mb;
  // UART presents an address every cycle, so outside the mailbox it always owns the RAM
  assign uart_ram    = ~uart_mb;
  assign cpu_mb_wr   = bus.cpu_wen & cpu_mb;
  assign uart_err_wr = bus.uart_wen & uart_mb & (uart_off == 2'd1);
  assign w1c         = cpu_mb_wr & (cpu_off == 2'd2);

  assign bus.cpu_stall = cpu_ram & (uart_ram | (state_q == S_TX));
  assign cpu_grant     = cpu_ram & ~bus.cpu_stall;
  assign bus.irq       = rx_done_q | tx_done_q | errf_q;

  assign cnt_ext = 32'(rx_cnt_q);
  assign stat    = {cnt_ext[15:0], 12'h0, errf_q, tx_done_q, rx_done_q, state_q != S_IDLE};

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wen   = 1'b0;
    bus.ram_wdata = '0;
    if (uart_ram) begin
      bus.ram_addr  = bus.uart_addr[ADDR_W-1:0];
      bus.ram_wen   = bus.uart_wen;
      bus.ram_wdata = bus.uart_wdata;
    end else if (cpu_grant) begin
      bus.ram_addr  = bus.cpu_addr[ADDR_W-1:0];
      bus.ram_wen   = bus.cpu_wen;
      bus.ram_wdata = bus.cpu_wdata;
    end
  end

  always_comb begin
    bus.uart_rdata = '0;
    if (uart_ram)              bus.uart_rdata = bus.ram_rdata;
    else if (uart_off == 2'd0) bus.uart_rdata = {31'h0, cmd_q};
    bus.cpu_rdata = '0;
    if (bus.cpu_ren & ~bus.cpu_stall) begin
      if (cpu_mb) begin
        case (cpu_off)
          2'd0:    bus.cpu_rdata = {31'h0, cmd_q};
          2'd1:    bus.cpu_rdata = err_q;
          2'd2:    bus.cpu_rdata = stat;
          default: bus.cpu_rdata = '0;
        endcase
      end else begin
        bus.cpu_rdata = bus.ram_rdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    err_d    = err_q;
    rx_cnt_d = rx_cnt_q;
    timer_d  = timer_q;
    set_rx   = 1'b0;
    set_tx   = 1'b0;
    clr_rx   = 1'b0;
    go_tx    = 1'b0;
    if (uart_err_wr) begin
      state_d = S_IDLE;
      err_d   = bus.uart_wdata;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (uart_ram & ~bus.uart_wen & cmd_q) begin
            state_d = S_TX;
            go_tx   = 1'b1;
          end else if (uart_ram & bus.uart_wen) begin
            state_d  = S_RX;
            rx_cnt_d = CNT_W'(1);
            timer_d  = '0;
            clr_rx   = 1'b1;
          end
        end
        S_TX: begin
          if (uart_mb) begin
            state_d = S_IDLE;
            set_tx  = 1'b1;
          end
        end
        S_RX: begin
          if (uart_ram & bus.uart_wen) begin
            if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TMR_W'(RX_IDLE_CYCLES - 1)) begin
              state_d = S_IDLE;
              set_rx  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (cpu_mb_wr & (cpu_off == 2'd0) & (state_q == S_IDLE)) cmd_d = bus.cpu_wdata[0];
    // session start and UART error both override a same-edge CPU command write
    if (go_tx | uart_err_wr) cmd_d = 1'b0;
    rx_done_d = (rx_done_q & ~(w1c & bus.cpu_wdata[1]) & ~clr_rx) | set_rx;
    tx_done_d = (tx_done_q & ~(w1c & bus.cpu_wdata[2])) | set_tx;
    errf_d    = (errf_q    & ~(w1c & bus.cpu_wdata[3])) | uart_err_wr;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cmd_q     <= 1'b0;
      err_q     <= '0;
      rx_done_q <= 1'b0;
      tx_done_q <= 1'b0;
      errf_q    <= 1'b0;
      rx_cnt_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      rx_done_q <= rx_done_d;
      tx_done_q <= tx_done_d;
      errf_q    <= errf_d;
      rx_cnt_q  <= rx_cnt_d;
      timer_q   <= timer_d;
    end
  end
endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Randomized + directed bench for uart_ram_arbiter against a session-level reference model.
module tb_uart_ram_arbiter;
  localparam int          AW   = 16;
  localparam logic [31:0] MB   = 32'h0007_0000;
  localparam int          RXI  = 64;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  uart_ram_arbiter_if #(.ADDR_W(AW)) bus();

  uart_ram_arbiter #(.ADDR_W(AW), .MBOX_BASE(MB), .RX_IDLE_CYCLES(RXI), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] mem  [0:65535];  // RAM behind the arbiter
  logic [31:0] emem [0:65535];  // model's view of RAM contents

  // reference model: session mode 0=idle 1=tx 2=rx
  int          m_mode, m_cnt, m_quiet;
  bit          m_cmd, m_rx, m_tx, m_er, m_stall;
  logic [31:0] m_errv;

  function automatic bit in_mb(input logic [31:0] a);
    return (a >> 2) == (MB >> 2);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cnt = 0; m_quiet = 0;
    m_cmd = 0; m_rx = 0; m_tx = 0; m_er = 0; m_errv = 0;
  endtask

  function automatic logic [31:0] m_stat();
    return (32'(m_cnt) << 16) | (32'(m_er) << 3) | (32'(m_tx) << 2) | (32'(m_rx) << 1)
           | 32'(m_mode != 0);
  endfunction

  task automatic idle_in();
    bus.cpu_addr = 0; bus.cpu_wen = 0; bus.cpu_ren = 0; bus.cpu_wdata = 0;
    bus.uart_addr = MB; bus.uart_wen = 0; bus.uart_wdata = 0;
  endtask

  task automatic cpu_rd(input logic [31:0] a);
    bus.cpu_addr = a; bus.cpu_ren = 1; bus.cpu_wen = 0; bus.cpu_wdata = 0;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_addr = a; bus.cpu_ren = 0; bus.cpu_wen = 1; bus.cpu_wdata = d;
  endtask

  task automatic cpu_idle();
    bus.cpu_addr = 0; bus.cpu_ren = 0; bus.cpu_wen = 0; bus.cpu_wdata = 0;
  endtask

  task automatic settle();
    #1;
    bus.ram_rdata = mem[bus.ram_addr];
    #1;
  endtask

  task automatic check_model();
    logic [31:0] ca, ua, ea, ed, eu, ec;
    bit umb, cmb, cram, ew;
    int coff, uoff;
    ca = bus.cpu_addr; ua = bus.uart_addr;
    umb = in_mb(ua); cmb = in_mb(ca);
    coff = int'(ca[1:0]); uoff = int'(ua[1:0]);
    cram = (bus.cpu_wen || bus.cpu_ren) && !cmb;
    m_stall = cram && (!umb || m_mode == 1);
    ea = 0; ew = 0; ed = 0;
    if (!umb) begin
      ea = 32'(ua[15:0]); ew = bus.uart_wen; ed = bus.uart_wdata;
    end else if (cram && !m_stall) begin
      ea = 32'(ca[15:0]); ew = bus.cpu_wen; ed = bus.cpu_wdata;
    end
    eu = !umb ? emem[ua[15:0]] : (uoff == 0 ? 32'(m_cmd) : 32'h0);
    ec = 0;
    if (bus.cpu_ren && !m_stall) begin
      if (!cmb)           ec = emem[ca[15:0]];
      else if (coff == 0) ec = 32'(m_cmd);
      else if (coff == 1) ec = m_errv;
      else if (coff == 2) ec = m_stat();
    end
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(m_stall));
    chk("ram_addr", 32'(bus.ram_addr), ea);
    chk("ram_wen", 32'(bus.ram_wen), 32'(ew));
    chk("ram_wdata", bus.ram_wdata, ed);
    chk("uart_rdata", bus.uart_rdata, eu);
    chk("cpu_rdata", bus.cpu_rdata, ec);
    chk("irq", 32'(bus.irq), 32'(m_rx | m_tx | m_er));
  endtask

  task automatic m_update();
    logic [31:0] ca, ua;
    bit cmb, umb, cwr_mb, uerr, u_wr, u_rd, go_tx, set_tx, set_rx, clr_rx;
    int coff, uoff, mode0;
    ca = bus.cpu_addr; ua = bus.uart_addr;
    cmb = in_mb(ca); umb = in_mb(ua);
    coff = int'(ca[1:0]); uoff = int'(ua[1:0]);
    cwr_mb = bus.cpu_wen && cmb;
    uerr = umb && bus.uart_wen && uoff == 1;
    u_wr = !umb && bus.uart_wen;
    u_rd = !umb && !bus.uart_wen;
    go_tx = 0; set_tx = 0; set_rx = 0; clr_rx = 0;
    mode0 = m_mode;
    if (u_wr) emem[ua[15:0]] = bus.uart_wdata;
    else if (umb && !cmb && bus.cpu_wen && m_mode != 1) emem[ca[15:0]] = bus.cpu_wdata;
    if (uerr) begin
      m_mode = 0; m_errv = bus.uart_wdata;
    end else if (mode0 == 0) begin
      if (u_rd && m_cmd) begin m_mode = 1; go_tx = 1; end
      else if (u_wr) begin m_mode = 2; m_cnt = 1; m_quiet = 0; clr_rx = 1; end
    end else if (mode0 == 1) begin
      if (umb) begin m_mode = 0; set_tx = 1; end
    end else begin
      if (u_wr) begin
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == RXI) begin m_mode = 0; set_rx = 1; end
      end
    end
    if (cwr_mb && coff == 0 && mode0 == 0) m_cmd = bus.cpu_wdata[0];
    if (go_tx || uerr) m_cmd = 0;
    if (cwr_mb && coff == 2) begin
      if (bus.cpu_wdata[1]) m_rx = 0;
      if (bus.cpu_wdata[2]) m_tx = 0;
      if (bus.cpu_wdata[3]) m_er = 0;
    end
    if (clr_rx) m_rx = 0;
    m_rx = m_rx | set_rx;
    m_tx = m_tx | set_tx;
    m_er = m_er | uerr;
  endtask

  task automatic fin();
    bit w;
    logic [AW-1:0] a;
    logic [31:0] d;
    check_model();
    w = bus.ram_wen; a = bus.ram_addr; d = bus.ram_wdata;
    if (nrst) m_update();
    else m_reset();
    @(posedge clk);
    if (w && nrst) mem[a] = d;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    fin();
  endtask

  int pulses;
  int seg, umode, r;

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = 0; emem[i] = 0; end
    idle_in();
    bus.ram_rdata = 0;
    m_reset();
    m_stall = 0;
    @(negedge clk);
    settle();
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_wen", 32'(bus.ram_wen), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_uart_rdata", bus.uart_rdata, 0);
    fin();
    nrst = 1;
    step();
    cpu_rd(MB + 2); settle(); chk("rst_stat", bus.cpu_rdata, 0); fin();

    // TX session
    cpu_wr(MB, 1); step();
    cpu_idle(); bus.uart_addr = MB; settle();
    chk("mbox_cmd_uart", bus.uart_rdata, 1); chk("mbox_ram_wen", 32'(bus.ram_wen), 0); fin();
    bus.uart_addr = 0; cpu_rd(MB + 2); settle(); chk("tx_pre_stat", bus.cpu_rdata, 0); fin();
    bus.uart_addr = 1; cpu_rd(MB); settle(); chk("tx_cmd_cleared", bus.cpu_rdata, 0); fin();
    bus.uart_addr = 2; cpu_rd(MB + 2); settle(); chk("tx_busy", bus.cpu_rdata, 1); fin();
    cpu_rd(32'h10);
    for (int i = 0; i < 4; i++) begin
      bus.uart_addr = 3 + i; settle(); chk("tx_stall", 32'(bus.cpu_stall), 1); fin();
    end
    cpu_wr(MB, 1); bus.uart_addr = 8; step();
    cpu_rd(32'h10); bus.uart_addr = MB; settle(); chk("tx_end_stall", 32'(bus.cpu_stall), 1); fin();
    cpu_rd(MB + 2); settle();
    chk("tx_done_stat", bus.cpu_rdata, 32'h4); chk("tx_irq", 32'(bus.irq), 1); fin();
    cpu_rd(MB); settle(); chk("cmd_ignored_in_tx", bus.cpu_rdata, 0); fin();
    cpu_wr(MB + 2, 4); step();
    cpu_rd(MB + 2); settle();
    chk("tx_w1c", bus.cpu_rdata, 0); chk("tx_w1c_irq", 32'(bus.irq), 0); fin();

    // CMD write racing the TX start: the clear wins
    cpu_wr(MB, 1); step();
    bus.uart_addr = 0; cpu_wr(MB, 1); step();
    cpu_idle(); bus.uart_addr = MB; step();
    cpu_rd(MB); settle(); chk("cmd_clear_wins", bus.cpu_rdata, 0); fin();
    cpu_wr(MB + 2, 4); step(); cpu_idle();

    // RX session
    pulses = 0;
    for (int w = 0; w < 5; w++) begin
      bus.uart_addr = w; bus.uart_wen = 1; bus.uart_wdata = w;
      settle(); if (bus.ram_wen) pulses++; fin();
      bus.uart_wen = 0; bus.uart_addr = MB + 2;
      repeat (40) begin settle(); if (bus.ram_wen) pulses++; fin(); end
    end
    chk("rx_wen_pulses", pulses, 5);
    repeat (RXI - 41) step();
    cpu_rd(MB + 2); settle(); chk("rx_not_yet_done", bus.cpu_rdata, 32'h0005_0001); fin();
    settle(); chk("rx_done_stat", bus.cpu_rdata, 32'h0005_0002); fin();
    cpu_wr(MB + 2, 2); step(); cpu_idle();

    // collision: UART owns the RAM, CPU write lands one cycle later
    bus.uart_addr = 3; bus.uart_wen = 1; bus.uart_wdata = 32'hAA; cpu_wr(32'h10, 32'hBB);
    settle();
    chk("col_ram_addr", 32'(bus.ram_addr), 3); chk("col_stall", 32'(bus.cpu_stall), 1); fin();
    bus.uart_addr = MB; bus.uart_wen = 0; settle();
    chk("col_land_stall", 32'(bus.cpu_stall), 0); chk("col_land_addr", 32'(bus.ram_addr), 32'h10);
    fin();
    cpu_rd(32'h10); settle(); chk("col_cpu_data", bus.cpu_rdata, 32'hBB); fin();

    // UART error mid-RX with racing W1C of err
    bus.uart_addr = MB + 1; bus.uart_wen = 1; bus.uart_wdata = 1; cpu_wr(MB + 2, 8); step();
    bus.uart_wen = 0; bus.uart_addr = MB; cpu_rd(MB + 2); settle();
    chk("exc_stat", bus.cpu_rdata, 32'h0001_0008); chk("exc_irq", 32'(bus.irq), 1); fin();
    cpu_rd(MB + 1); settle(); chk("exc_errv", bus.cpu_rdata, 1); fin();
    cpu_wr(MB + 2, 8); step();
    cpu_rd(MB + 2); settle(); chk("err_w1c", bus.cpu_rdata, 32'h0001_0000); fin();

    // reset in the middle of a TX session
    cpu_wr(MB, 1); step(); cpu_idle();
    bus.uart_addr = 5; step();
    bus.uart_addr = 6; step();
    nrst = 0; idle_in(); m_reset(); settle();
    chk("rstmid_stall", 32'(bus.cpu_stall), 0); chk("rstmid_ram_addr", 32'(bus.ram_addr), 0);
    chk("rstmid_irq", 32'(bus.irq), 0); chk("rstmid_uart_rdata", bus.uart_rdata, 0);
    fin();
    nrst = 1; step();
    cpu_rd(MB + 2); settle(); chk("rstmid_stat", bus.cpu_rdata, 0); fin();
    cpu_rd(MB + 1); settle(); chk("rstmid_errv", bus.cpu_rdata, 0); fin();

    // randomized traffic
    seg = 0; umode = 0;
    repeat (4000) begin
      if (seg == 0) begin seg = $urandom_range(1, 150); umode = $urandom_range(0, 2); end
      seg--;
      bus.uart_wdata = $urandom;
      bus.uart_wen = 0;
      if (umode == 0) begin
        bus.uart_addr = MB + $urandom_range(0, 3);
        bus.uart_wen = ($urandom_range(0, 40) == 0);
      end else if (umode == 1) begin
        bus.uart_addr = $urandom_range(0, 31) | ($urandom_range(0, 1) ? 32'h0001_0000 : 32'h0);
      end else if ($urandom_range(0, 3) == 0) begin
        bus.uart_addr = $urandom_range(0, 31); bus.uart_wen = 1;
      end else begin
        bus.uart_addr = MB + 2;
      end
      if (!m_stall) begin
        r = $urandom_range(0, 9);
        if (r < 3) cpu_idle();
        else if (r < 6) cpu_rd($urandom_range(0, 31) | ($urandom_range(0, 1) ? 32'h0001_0000 : 32'h0));
        else if (r < 8) cpu_wr($urandom_range(0, 31), $urandom);
        else if (r == 8) cpu_rd(MB + $urandom_range(0, 3));
        else cpu_wr(MB + $urandom_range(0, 3), 32'($urandom_range(0, 15)));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
